// File: rtl/iprf_wb_arb_pkg.sv
// Shared types and constants for the integer PRF writeback path.
package iprf_wb_arb_pkg;

  localparam int IPRF_NUM_WRITES    = 2;
  localparam int IPRF_WB_FIFO_DEPTH = 2;
  localparam int PRF_PDST_W         = 7;
  localparam int PRF_DATA_W         = 32;

  typedef struct packed {
    logic [PRF_PDST_W-1:0] pdst;
    logic [PRF_DATA_W-1:0] data;
  } t_prf_wr_pkt;

  // Folds an index in [0, 2n) back into [0, n).
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/iprf_wb_arb_fifo.sv
// Single-source circular result queue with push/pop, head, count and full/empty flags.
module iprf_wb_arb_fifo
  import iprf_wb_arb_pkg::*;
#(
  parameter int DEPTH = IPRF_WB_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  t_prf_wr_pkt            push_pkt,
  input  logic                   pop,
  output t_prf_wr_pkt            head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  t_prf_wr_pkt      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset: stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_pkt;
  end

endmodule

// File: rtl/iprf_wb_arb.sv
// IPRF writeback arbiter: per-pipe queues, round-robin multi-grant onto NUM_WR registered write ports.
// Optional same-cycle bypass of empty queues with IPRF_WB_BYPASS_EN; duplicate-pdst check with ASSERT.
module iprf_wb_arb
  import iprf_wb_arb_pkg::*;
#(
  parameter int NUM_SRCS   = 4,
  parameter int FIFO_DEPTH = IPRF_WB_FIFO_DEPTH,
  parameter int NUM_WR     = IPRF_NUM_WRITES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRCS-1:0]       src_vld,
  input  t_prf_wr_pkt [NUM_SRCS-1:0] src_pkt,
  output logic [NUM_SRCS-1:0]       src_rdy,
  output logic                      iprf_wr_en_ro0 [NUM_WR],
  output t_prf_wr_pkt               iprf_wr_pkt_ro0 [NUM_WR],
  output logic                      wb_busy
);

  localparam int SRC_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRCS-1:0]          fifo_full;
  logic [NUM_SRCS-1:0]          fifo_empty;
  logic [NUM_SRCS-1:0]          fifo_push;
  logic [NUM_SRCS-1:0]          fifo_pop;
  logic [NUM_SRCS-1:0]          req;
  logic [NUM_SRCS-1:0]          gnt;
  t_prf_wr_pkt                  fifo_head  [NUM_SRCS];
  logic [CNT_W-1:0]             fifo_count [NUM_SRCS];
  logic [SRC_W-1:0]             rr_ptr_reg;
  logic [SRC_W-1:0]             rr_ptr_next;
  logic [NUM_WR-1:0]            port_vld;
  logic [NUM_WR-1:0][SRC_W-1:0] port_src;
  t_prf_wr_pkt                  port_pkt   [NUM_WR];
  logic                         last_vld;
  logic [SRC_W-1:0]             last_src;
  logic [NUM_WR-1:0]            wr_en_reg;
  t_prf_wr_pkt                  wr_pkt_reg [NUM_WR];

  // Scans the doubled request vector from start; the k-th hit in scan order owns port k.
  function automatic void rr_select(
    input  logic [2*NUM_SRCS-1:0]        req2,
    input  logic [SRC_W-1:0]             start,
    output logic [NUM_SRCS-1:0]          g,
    output logic [NUM_WR-1:0]            pv,
    output logic [NUM_WR-1:0][SRC_W-1:0] ps,
    output logic                         lv,
    output logic [SRC_W-1:0]             ls
  );
    int n;
    int s;
    g  = '0;
    pv = '0;
    ps = '0;
    lv = 1'b0;
    ls = '0;
    n  = 0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      s = rr_wrap(int'(start) + i, NUM_SRCS);
      if (req2[int'(start) + i] && (n < NUM_WR)) begin
        g[s]  = 1'b1;
        pv[n] = 1'b1;
        ps[n] = SRC_W'(s);
        lv    = 1'b1;
        ls    = SRC_W'(s);
        n++;
      end
    end
  endfunction

  for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_src
    logic byp_take;
`ifdef IPRF_WB_BYPASS_EN
    assign req[gi]  = !fifo_empty[gi] || (src_vld[gi] && src_rdy[gi]);
    assign byp_take = fifo_empty[gi] && gnt[gi];
`else
    assign req[gi]  = !fifo_empty[gi];
    assign byp_take = 1'b0;
`endif
    assign src_rdy[gi]   = reset && !fifo_full[gi];
    assign fifo_push[gi] = src_vld[gi] && src_rdy[gi] && !byp_take;
    assign fifo_pop[gi]  = gnt[gi] && !fifo_empty[gi];

    iprf_wb_arb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push[gi]),
      .push_pkt (src_pkt[gi]),
      .pop      (fifo_pop[gi]),
      .head     (fifo_head[gi]),
      .count    (fifo_count[gi]),
      .full     (fifo_full[gi]),
      .empty    (fifo_empty[gi])
    );
  end

  always_comb begin
    rr_select({req, req}, rr_ptr_reg, gnt, port_vld, port_src, last_vld, last_src);
    rr_ptr_next = rr_ptr_reg;
    if (last_vld) rr_ptr_next = SRC_W'(rr_wrap(int'(last_src) + 1, NUM_SRCS));
  end

  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      port_pkt[k] = fifo_head[port_src[k]];
`ifdef IPRF_WB_BYPASS_EN
      if (fifo_empty[port_src[k]]) port_pkt[k] = src_pkt[port_src[k]];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg <= '0;
      wr_en_reg  <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      wr_en_reg  <= port_vld;
    end
  end

  // Packet flops load only on grant; their contents are don't-care while en is low.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_WR; k++) begin
      if (port_vld[k]) wr_pkt_reg[k] <= port_pkt[k];
    end
  end

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_port
    assign iprf_wr_en_ro0[gi]  = wr_en_reg[gi];
    assign iprf_wr_pkt_ro0[gi] = wr_pkt_reg[gi];
  end

  always_comb begin
    wb_busy = |wr_en_reg;
    for (int s = 0; s < NUM_SRCS; s++) begin
      if (fifo_count[s] != '0) wb_busy = 1'b1;
    end
  end

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < NUM_WR; a++) begin
        for (int b = a + 1; b < NUM_WR; b++) begin
          assert (!(port_vld[a] && port_vld[b] && (port_pkt[a].pdst == port_pkt[b].pdst)))
            else $error("iprf_wb_arb: two grants to pdst %0d in one cycle", port_pkt[a].pdst);
        end
      end
    end
  end
`endif

endmodule

// File: doc/iprf_wb_arb.md
# iprf_wb_arb

Integer PRF writeback arbiter: the producer side of the IPRF write-port bus that reservation-station source trackers snoop to wake up pending operands. Collects completed results from NUM_SRCS execution pipes through per-pipe valid/ready queues. Grants up to IPRF_NUM_WRITES of them per cycle in round-robin order. Drives the registered `iprf_wr_en_ro0`/`iprf_wr_pkt_ro0` arrays consumed by the PRF and every RS entry.

## Interface
- NUM_SRCS, 4, number of result-producing execution pipes (≥ IPRF_NUM_WRITES)
- FIFO_DEPTH, 2, entries per source queue (power of two, ≥ 2)
- NUM_WR, IPRF_NUM_WRITES, PRF write ports driven
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- src_vld  in  [NUM_SRCS-1:0]  result valid per pipe
- src_pkt  in  t_prf_wr_pkt [NUM_SRCS-1:0]  result packet (pdst, data)
- src_rdy  out  [NUM_SRCS-1:0]  queue can accept; transfer when src_vld & src_rdy
- iprf_wr_en_ro0  out  logic [NUM_WR-1:0] (unpacked)  write-port valid
- iprf_wr_pkt_ro0  out  t_prf_wr_pkt [NUM_WR-1:0] (unpacked)  write-port packet
- wb_busy  out  1  any queue non-empty or any write port valid

## Operation
- Per-source FIFO: circular, rd/wr pointers of clog2(FIFO_DEPTH) bits wrap modulo depth. Count is clog2(FIFO_DEPTH)+1 bits.
- src_rdy[s] = count[s] < FIFO_DEPTH, computed from the current count only. No pop-through: a full queue deasserts rdy even when it is popped in the same cycle.
- Push on src_vld & src_rdy. A push and a pop in the same cycle leave the count unchanged.
- Arbitration each cycle over non-empty queues:
  - Scan starts at rr_ptr and proceeds s = rr_ptr, rr_ptr+1, … mod NUM_SRCS.
  - The first NUM_WR non-empty queues are granted.
  - The k-th grant in scan order goes to write port k.
  - Each queue pops at most one entry per cycle.
- rr_ptr update: becomes (index of last granted source + 1) mod NUM_SRCS. It is unchanged when nothing is granted.
- Output stage: iprf_wr_en_ro0[k] and iprf_wr_pkt_ro0[k] are flopped from grant k every cycle. Ungranted ports drive en = 0. Packet contents are don't-care when en = 0; packet flops are enabled only on grant.
- No backpressure from the PRF: every granted packet is written exactly once.
- Two grants to the same pdst in one cycle are illegal upstream. Under ASSERT this is flagged by an assertion.
- Reset (reset = 0, any time):
  - All queues empty; pointers and counts 0.
  - rr_ptr = 0.
  - iprf_wr_en_ro0 all 0.
  - src_rdy all 0 while in reset; all 1 the first cycle after release.
  - wb_busy = 0.
  - In-flight queue contents are discarded.

## Timing
- Default path: a packet accepted at the edge ending cycle T sits at the queue head in T+1. It is granted in T+1 if it wins, and appears on iprf_wr_en_ro0 in T+2.
- Steady state: each source sustains one result per cycle when FIFO_DEPTH ≥ 2 and it wins every cycle.
- Fairness: a non-empty queue is granted within ceil(NUM_SRCS/NUM_WR) cycles.
- wb_busy is combinational from the counts and the output valid flops.

## Configuration
- IPRF_WB_BYPASS_EN defined:
  - When queue s is empty and src_vld[s] is high, the incoming packet competes in that same cycle's arbitration at position s.
  - If granted, the packet is written directly to the output flop and the FIFO is not written. Latency is 1 cycle (accepted in T, visible in T+1).
  - If not granted, it is enqueued normally.
- IPRF_WB_BYPASS_EN undefined: queue-only path with a fixed 2-cycle minimum latency. No input-to-grant combinational path.

## Structure
- common.pkg: t_prf_wr_pkt (already present) and IPRF_NUM_WRITES; add IPRF_WB_FIFO_DEPTH default constant.
- Sub-module wb_arb_fifo: single-source queue with push/pop, head, count and full/empty, instantiated NUM_SRCS times.
- Round-robin multi-grant selection lives in the top module as a function over a doubled request vector.

## Test plan
- Reset release, single push src 2 pdst=5 data=0xAA at T:
  - without bypass: port0 en=1, pdst 5, data 0xAA at T+2;
  - with bypass: same at T+1;
  - exactly one cycle in both cases.
- All 4 sources push every cycle with NUM_WR=2, rr_ptr=0: grants {0,1},{2,3},{0,1}… on ports {0,1}. No packet is lost or duplicated across 100 cycles. Each source is throttled to 50% via src_rdy.
- Fill src 1 with 2 entries, no grants possible (force other sources ahead): src_rdy[1]=0 while full. It stays 0 in the pop cycle and returns to 1 one cycle after the pop.
- Wrap-around: 10 back-to-back pushes/pops on one source with FIFO_DEPTH=2. Outputs stay in push order (data 0..9).
- Assert reset mid-stream with 3 queued entries and port0 valid: outputs drop to 0 asynchronously. After release, no stale packets appear, rr_ptr restarts at 0 and wb_busy=0.
